// File: rtl/ierl78_prtyerr_capture_if.sv
// Host register-access bus for the parity-error capture block.
// The host (master) drives address, write data and write strobe; the block returns read data.
interface ierl78_prtyerr_capture_if;
    logic [31:0] ICEIFA;
    logic [15:0] ICEDI;
    logic        ICEWR;
    logic [31:0] ICEDOPB;

    modport master (output ICEIFA, output ICEDI, output ICEWR, input  ICEDOPB);
    modport slave  (input  ICEIFA, input  ICEDI, input  ICEWR, output ICEDOPB);
endinterface

// File: rtl/ierl78_prtyerr_capture.sv
// RAM parity-error capture: one event per RPERR rising edge, sticky flag, reset request
// sequencer, optional break pulse, and host-visible first-error address and error counter.
module ierl78_prtyerr_capture #(
    parameter int RSTW = 4,
    parameter int CNTW = 8
) (
    input  logic                       BASECK,
    input  logic                       SYSRSOUT,
    input  logic                       RPERR,
    input  logic [15:0]                MA,
    input  logic                       RPERDIS,
    input  logic                       RPEFCLR,
    ierl78_prtyerr_capture_if.slave    host,
    output logic                       RPEF,
    output logic                       PRSTREQ,
    output logic                       PEBRK
);

    localparam logic [31:0]     ADR_CTLSTS = 32'h0401_0004;
    localparam logic [31:0]     ADR_CAPADR = 32'h0401_0006;
    localparam int              WCW        = (RSTW > 1) ? $clog2(RSTW) : 1;
    localparam logic [WCW-1:0]  WCNT_LOAD  = WCW'(RSTW - 1);
    localparam logic [WCW-1:0]  WCNT_ZERO  = {WCW{1'b0}};
    localparam logic [WCW-1:0]  WCNT_ONE   = WCW'(32'd1);
    localparam logic [CNTW-1:0] CNT_MAX    = {CNTW{1'b1}};
    localparam logic [CNTW-1:0] CNT_ONE    = CNTW'(32'd1);
    localparam logic [CNTW-1:0] CNT_ZERO   = {CNTW{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RSTA = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t          state_r, state_nxt_s;
    logic [WCW-1:0]  wcnt_r, wcnt_nxt_s;
    logic            rperr_in_r, rperr_q_r;
    logic [15:0]     ma_r;
    logic [CNTW-1:0] cnt_r, cnt_nxt_s;
    logic            vld_r, vld_nxt_s;
    logic [15:0]     cap_adr_r, cap_adr_nxt_s;
    logic            brken_r, brken_nxt_s;
    logic            rpef_r, rpef_nxt_s;
    logic            prstreq_r, pebrk_r;
    logic            ev_s, wr_ctl_s, clr_s;
    logic [13:0]     cnt_ext_s;
    logic            unused_icedi_s;

    // RPERR and MA are first registered together; the event is the rising edge of that stage
    assign ev_s     = rperr_in_r & ~rperr_q_r;
    assign wr_ctl_s = host.ICEWR & (host.ICEIFA == ADR_CTLSTS);
    assign clr_s    = wr_ctl_s & host.ICEDI[0];
    assign cnt_ext_s = 14'(cnt_r);
    assign unused_icedi_s = ^host.ICEDI[15:2];

    assign RPEF    = rpef_r;
    assign PRSTREQ = prstreq_r;
    assign PEBRK   = pebrk_r;

    // Reset-request sequencer: next state and pulse-width counter
    always_comb begin
        state_nxt_s = state_r;
        wcnt_nxt_s  = wcnt_r;
        case (state_r)
            ST_IDLE: begin
                if (ev_s && !RPERDIS) begin
                    state_nxt_s = ST_RSTA;
                    wcnt_nxt_s  = WCNT_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RSTA: begin
                if (wcnt_r == WCNT_ZERO) begin
                    state_nxt_s = ST_HOLD;
                end else begin
                    wcnt_nxt_s = wcnt_r - WCNT_ONE;
                end
            end
            ST_HOLD: begin
                if (!rperr_q_r) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                wcnt_nxt_s  = WCNT_ZERO;
            end
        endcase
    end

    // Capture datapath: an event always wins over a coincident host clear or flag clear
    always_comb begin
        cnt_nxt_s     = cnt_r;
        vld_nxt_s     = vld_r;
        cap_adr_nxt_s = cap_adr_r;
        brken_nxt_s   = brken_r;
        rpef_nxt_s    = rpef_r;

        if (ev_s) begin
            if (clr_s) begin
                cnt_nxt_s = CNT_ONE;
            end else if (cnt_r != CNT_MAX) begin
                cnt_nxt_s = cnt_r + CNT_ONE;
            end else begin
                cnt_nxt_s = cnt_r;
            end
        end else if (clr_s) begin
            cnt_nxt_s = CNT_ZERO;
        end else begin
            cnt_nxt_s = cnt_r;
        end

        if (ev_s && (!vld_r || clr_s)) begin
            vld_nxt_s     = 1'b1;
            cap_adr_nxt_s = ma_r;
        end else if (clr_s) begin
            vld_nxt_s     = 1'b0;
            cap_adr_nxt_s = 16'h0000;
        end else begin
            vld_nxt_s     = vld_r;
            cap_adr_nxt_s = cap_adr_r;
        end

        if (wr_ctl_s) begin
            brken_nxt_s = host.ICEDI[1];
        end else begin
            brken_nxt_s = brken_r;
        end

        if (ev_s) begin
            rpef_nxt_s = 1'b1;
        end else if (RPEFCLR) begin
            rpef_nxt_s = 1'b0;
        end else begin
            rpef_nxt_s = rpef_r;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge BASECK) begin
        if (SYSRSOUT) begin
            state_r    <= ST_IDLE;
            wcnt_r     <= WCNT_ZERO;
            rperr_in_r <= 1'b0;
            rperr_q_r  <= 1'b0;
            ma_r       <= 16'h0000;
            cnt_r      <= CNT_ZERO;
            vld_r      <= 1'b0;
            cap_adr_r  <= 16'h0000;
            brken_r    <= 1'b0;
            rpef_r     <= 1'b0;
            prstreq_r  <= 1'b0;
            pebrk_r    <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            wcnt_r     <= wcnt_nxt_s;
            rperr_in_r <= RPERR;
            rperr_q_r  <= rperr_in_r;
            ma_r       <= MA;
            cnt_r      <= cnt_nxt_s;
            vld_r      <= vld_nxt_s;
            cap_adr_r  <= cap_adr_nxt_s;
            brken_r    <= brken_nxt_s;
            rpef_r     <= rpef_nxt_s;
            prstreq_r  <= (state_nxt_s == ST_RSTA);
            pebrk_r    <= ev_s & brken_r;
        end
    end

    // Host read mux, combinational from the address
    always_comb begin
        case (host.ICEIFA)
            ADR_CTLSTS: host.ICEDOPB = {16'h0000, cnt_ext_s, brken_r, vld_r};
            ADR_CAPADR: host.ICEDOPB = {16'h0000, cap_adr_r};
            default:    host.ICEDOPB = 32'h0000_0000;
        endcase
    end

endmodule

// File: tb/tb_ierl78_prtyerr_capture.sv
// Directed self-checking bench for ierl78_prtyerr_capture (RSTW=4, CNTW=8).
module tb_ierl78_prtyerr_capture;

    localparam logic [31:0] CTLSTS = 32'h0401_0004;
    localparam logic [31:0] CAPADR = 32'h0401_0006;

    logic        clk = 1'b0;
    logic        srs, rperr, rperdis, rpefclr;
    logic [15:0] ma;
    logic        rpef, prst, pebrk;
    logic [31:0] rd;
    logic [8:1]  exp_prst;
    int          n_cmp = 0;
    int          n_err = 0;
    int          prst_cnt = 0;
    int          brk_cnt = 0;

    ierl78_prtyerr_capture_if bus ();

    ierl78_prtyerr_capture #(.RSTW(4), .CNTW(8)) dut (
        .BASECK   (clk),
        .SYSRSOUT (srs),
        .RPERR    (rperr),
        .MA       (ma),
        .RPERDIS  (rperdis),
        .RPEFCLR  (rpefclr),
        .host     (bus),
        .RPEF     (rpef),
        .PRSTREQ  (prst),
        .PEBRK    (pebrk)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
        prst_cnt += (prst === 1'b1) ? 1 : 0;
        brk_cnt  += (pebrk === 1'b1) ? 1 : 0;
    endtask

    task automatic host_rd(input logic [31:0] a, output logic [31:0] d);
        bus.ICEIFA = a;
        #1;
        d = bus.ICEDOPB;
    endtask

    task automatic host_wr(input logic [31:0] a, input logic [15:0] d);
        bus.ICEIFA = a;
        bus.ICEDI  = d;
        bus.ICEWR  = 1'b1;
        step();
        bus.ICEWR  = 1'b0;
    endtask

    task automatic err_pulse(input logic [15:0] a, input int hold);
        rperr = 1'b1;
        ma    = a;
        repeat (hold) step();
        rperr = 1'b0;
        ma    = 16'hFFFF;
        repeat (8) step();
    endtask

    initial begin
        srs = 1'b1; rperr = 1'b0; rperdis = 1'b0; rpefclr = 1'b0; ma = 16'h0000;
        bus.ICEIFA = 32'h0; bus.ICEDI = 16'h0; bus.ICEWR = 1'b0;
        repeat (3) step();
        srs = 1'b0;
        step();

        chk_eq("rst_rpef", rpef, 0);
        chk_eq("rst_prst", prst, 0);
        chk_eq("rst_pebrk", pebrk, 0);
        host_rd(CTLSTS, rd); chk_eq("rst_ctlsts", rd, 32'h0);
        host_rd(CAPADR, rd); chk_eq("rst_capadr", rd, 32'h0);

        // single error, reset enabled, RPERR high 3 clocks
        exp_prst = 8'b0001_1110;
        rperr = 1'b1; ma = 16'hF3A0;
        for (int i = 1; i <= 8; i++) begin
            step();
            chk_eq($sformatf("prst_t%0d", i), prst, exp_prst[i]);
            if (i == 2) chk_eq("nobrk_t2", pebrk, 0);
            if (i == 3) begin rperr = 1'b0; ma = 16'hFFFF; end
        end
        chk_eq("single_rpef", rpef, 1);
        host_rd(CTLSTS, rd); chk_eq("single_ctlsts", rd, 32'h5);
        host_rd(CAPADR, rd); chk_eq("single_capadr", rd, 32'h0000_F3A0);
        host_rd(32'h0401_0005, rd); chk_eq("other_adr", rd, 32'h0);

        // plain clear, then two errors with reset disabled
        host_wr(CTLSTS, 16'h0001);
        host_rd(CTLSTS, rd); chk_eq("clr_ctlsts", rd, 32'h0);
        host_rd(CAPADR, rd); chk_eq("clr_capadr", rd, 32'h0);
        rperdis = 1'b1;
        prst_cnt = 0;
        err_pulse(16'h1000, 1);
        err_pulse(16'h2000, 2);
        chk_eq("dis_prst_cnt", prst_cnt, 0);
        host_rd(CTLSTS, rd); chk_eq("dis_ctlsts", rd, 32'h9);
        host_rd(CAPADR, rd); chk_eq("dis_capadr", rd, 32'h0000_1000);

        // break enable and a one-clock PEBRK
        host_wr(CTLSTS, 16'h0002);
        host_rd(CTLSTS, rd); chk_eq("brken_ctlsts", rd, 32'hB);
        rperr = 1'b1; ma = 16'h3C3C;
        step(); chk_eq("brk_e0", pebrk, 0);
        rperr = 1'b0;
        step(); chk_eq("brk_e1", pebrk, 1);
        step(); chk_eq("brk_e2", pebrk, 0);
        repeat (4) step();
        host_rd(CTLSTS, rd); chk_eq("brk_ctlsts", rd, 32'hF);
        host_rd(CAPADR, rd); chk_eq("brk_capadr_first", rd, 32'h0000_1000);

        // 300 alternating events: counter saturates
        brk_cnt = 0;
        for (int i = 0; i < 300; i++) begin
            rperr = 1'b1; ma = 16'(i);
            step();
            rperr = 1'b0;
            step();
        end
        step();
        host_rd(CTLSTS, rd); chk_eq("sat_ctlsts", rd, 32'h3FF);
        chk_eq("sat_brk_cnt", brk_cnt, 300);

        // clear coincident with an event: the event wins
        rperr = 1'b1; ma = 16'hABCD;
        step();
        bus.ICEIFA = CTLSTS; bus.ICEDI = 16'h0001; bus.ICEWR = 1'b1;
        rperr = 1'b0; ma = 16'hFFFF;
        step();
        bus.ICEWR = 1'b0;
        host_rd(CTLSTS, rd); chk_eq("clrev_ctlsts", rd, 32'h5);
        host_rd(CAPADR, rd); chk_eq("clrev_capadr", rd, 32'h0000_ABCD);

        // RPEFCLR with an event, then alone
        rperr = 1'b1; ma = 16'h1111;
        step();
        rpefclr = 1'b1; rperr = 1'b0;
        step();
        rpefclr = 1'b0;
        chk_eq("rpefclr_ev", rpef, 1);
        rpefclr = 1'b1;
        step();
        rpefclr = 1'b0;
        chk_eq("rpefclr_alone", rpef, 0);

        // SYSRSOUT in the middle of a reset pulse
        rperdis = 1'b0;
        repeat (3) step();
        rperr = 1'b1; ma = 16'h5555;
        step(); chk_eq("mid_e0_prst", prst, 0);
        rperr = 1'b0;
        step(); chk_eq("mid_e1_prst", prst, 1);
        srs = 1'b1;
        step();
        srs = 1'b0;
        chk_eq("mid_rst_prst", prst, 0);
        chk_eq("mid_rst_rpef", rpef, 0);
        chk_eq("mid_rst_pebrk", pebrk, 0);
        host_rd(CTLSTS, rd); chk_eq("mid_rst_ctlsts", rd, 32'h0);
        host_rd(CAPADR, rd); chk_eq("mid_rst_capadr", rd, 32'h0);
        step(); chk_eq("mid_post_prst", prst, 0);

        // fresh error after reset: new full pulse
        prst_cnt = 0;
        rperr = 1'b1; ma = 16'h0123;
        step(); chk_eq("new_e0_prst", prst, 0);
        rperr = 1'b0; ma = 16'hFFFF;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk_eq($sformatf("new_prst_e%0d", i), prst, 1);
        end
        step(); chk_eq("new_prst_e5", prst, 0);
        repeat (6) step();
        chk_eq("new_prst_cnt", prst_cnt, 4);
        chk_eq("new_rpef", rpef, 1);
        host_rd(CTLSTS, rd); chk_eq("new_ctlsts", rd, 32'h5);
        host_rd(CAPADR, rd); chk_eq("new_capadr", rd, 32'h0000_0123);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
